bram_fifo_ctrl: RTL and testbench

//   FIFO controller that drives a simple dual-port block RAM.
//   - BRAM ports: wren/wraddress/data_in on write; oen/rdaddress/data_out on read, 1-cycle read latency.
//   - Turns the BRAM into a first-word-fall-through byte FIFO with valid/ready on both sides.
//   - Sits directly upstream of the BRAM: generates all addresses and enables.
//   - The BRAM's registered read data is used unchanged as the FIFO output register.

---
 rtl/bram_fifo_ctrl.sv | 95 +++++++++
 tb/tb_bram_fifo_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: first-word-fall-through FIFO controller for a simple
// dual-port BRAM with one cycle of read latency. The controller owns every
// BRAM address and enable. The BRAM's registered read port is the FIFO
// output register, so out_data is wired straight from mem_rdata.
//
// Optional build macro BRAM_FIFO_LEVEL_EN adds two ports: `level` (total
// words held) and `almost_full` (level >= AF_THRESH).
module bram_fifo_ctrl #(
    parameter int BITS      = 11,
    parameter int WIDTH     = 8,
    parameter int AF_THRESH = (1 << BITS) - 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             mem_wren,
    output logic [BITS-1:0]  mem_waddr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_oen,
    output logic [BITS-1:0]  mem_raddr,
    input  logic [WIDTH-1:0] mem_rdata
`ifdef BRAM_FIFO_LEVEL_EN
    ,
    output logic [BITS+1:0]  level,
    output logic             almost_full
`endif
);

    // mem_count is one bit wider than the pointers so that "full" and
    // "empty" can be told apart without a separate flag.
    localparam logic [BITS:0] DEPTH = {1'b1, {BITS{1'b0}}};

    // A threshold above the total capacity (BRAM plus output register)
    // could never be reached, so it is rejected when the design is built.
    if (AF_THRESH > (1 << BITS) + 1) begin : g_bad_thresh
        $error("AF_THRESH exceeds FIFO capacity");
    end

    logic [BITS-1:0] wptr;
    logic [BITS-1:0] rptr;
    logic [BITS:0]   mem_count;
    logic            wr;
    logic            rd;

    // in_ready is decoded only from registers, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready = (mem_count != DEPTH);
    assign wr       = in_valid & in_ready;

    // Issue a read whenever the output register is empty or is being
    // drained this cycle. This keeps reads back to back with no bubble.
    assign rd       = (mem_count != '0) & (~out_valid | out_ready);

    assign mem_wren  = wr;
    assign mem_waddr = wptr;
    assign mem_wdata = in_data;
    assign mem_oen   = rd;
    assign mem_raddr = rptr;

    // The BRAM holds data_out while oen is low, so the head word stays
    // stable during a stall.
    assign out_data  = mem_rdata;

    // Pointer, occupancy and output-valid state. The pointers wrap
    // naturally at 2**BITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
        end else begin
            wptr <= wptr + BITS'(wr);
            rptr <= rptr + BITS'(rd);
            case ({wr, rd})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
            out_valid <= rd | (out_valid & ~out_ready);
        end
    end

`ifdef BRAM_FIFO_LEVEL_EN
    // Total occupancy counts the word held in the output register.
    assign level       = {1'b0, mem_count} + (BITS+2)'(out_valid);
    assign almost_full = (level >= (BITS+2)'(AF_THRESH));
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed testbench for bram_fifo_ctrl. It attaches a behavioural BRAM
// model with one cycle of read latency. Inputs are driven 1 time unit
// after each rising edge, and outputs are sampled 2 units after it.
module tb_bram_fifo_ctrl;

    localparam int BITS  = 11;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             mem_wren;
    logic [BITS-1:0]  mem_waddr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_oen;
    logic [BITS-1:0]  mem_raddr;
    logic [WIDTH-1:0] mem_rdata;
`ifdef BRAM_FIFO_LEVEL_EN
    logic [BITS+1:0]  level;
    logic             almost_full;
`endif

    bram_fifo_ctrl #(.BITS(BITS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .mem_wren  (mem_wren),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_oen   (mem_oen),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
`ifdef BRAM_FIFO_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    always #5 clk = ~clk;

    // Simple dual-port BRAM: registered read, and data_out holds while oen is low.
    logic [WIDTH-1:0] bram [0:(1<<BITS)-1];
    always @(posedge clk) begin
        if (mem_wren) bram[mem_waddr] <= mem_wdata;
        if (mem_oen)  mem_rdata <= bram[mem_raddr];
    end

    int checks   = 0;
    int failures = 0;

    int got, sent, acc, bub;
    bit primed, rdy_ok, wrapw, wrapr;
    logic [BITS-1:0] prev_waddr, prev_raddr;
    logic [7:0] expb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        step(); step();
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wren",      32'(mem_wren),  32'd0);
        chk("rst_oen",       32'(mem_oen),   32'd0);
        chk("rst_waddr",     32'(mem_waddr), 32'd0);
        chk("rst_raddr",     32'(mem_raddr), 32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
        chk("rst_level",     32'(level),       32'd0);
        chk("rst_af",        32'(almost_full), 32'd0);
`endif
        rst = 1'b0;
        step();

        // 1: single word, FWFT latency
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        #1;
        chk("t1_wren",  32'(mem_wren),  32'd1);
        chk("t1_waddr", 32'(mem_waddr), 32'd0);
        chk("t1_wdata", 32'(mem_wdata), 32'hA5);
        step();
        in_valid = 1'b0;
        #1;
        chk("t1_ov_e1",  32'(out_valid), 32'd0);
        chk("t1_oen_e1", 32'(mem_oen),   32'd1);
        chk("t1_raddr",  32'(mem_raddr), 32'd0);
        step();
        #1;
        chk("t1_ov_e2",   32'(out_valid), 32'd1);
        chk("t1_data",    32'(out_data),  32'hA5);
        chk("t1_oen_e2",  32'(mem_oen),   32'd0);
        step();
        #1;
        chk("t1_ov_e3",   32'(out_valid), 32'd0);

        // 2: stream 0x00..0xFF, no bubbles once primed
        got = 0; bub = 0; primed = 0; rdy_ok = 1;
        for (int c = 0; c < 262; c++) begin
            in_valid = (c < 256);
            in_data  = 8'(c);
            #1;
            if (in_valid && !in_ready) rdy_ok = 0;
            if (out_valid) begin
                primed = 1;
                expb = 8'(got);
                chk("t2_data", 32'(out_data), 32'(expb));
                got++;
            end else if (primed && got < 256) begin
                bub++;
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("t2_count",   32'(got),       32'd256);
        chk("t2_bubbles", 32'(bub),       32'd0);
        chk("t2_ready",   32'(rdy_ok),    32'd1);
        chk("t2_empty",   32'(out_valid), 32'd0);
        step();

        // 3: fill to capacity (2048 in BRAM + 1 in the output register)
        out_ready = 1'b0; acc = 0;
        for (int c = 0; c < 2049; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(c) ^ 8'h5A;
            #1;
            if (in_ready) acc++;
            step();
        end
        in_data = 8'hEE;
        #1;
        chk("t3_accepted",   32'(acc),      32'd2049);
        chk("t3_full_ready", 32'(in_ready), 32'd0);
        chk("t3_drop_wren",  32'(mem_wren), 32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
        chk("t3_level",      32'(level),       32'd2049);
        chk("t3_af",         32'(almost_full), 32'd1);
`endif
        step(); step();
        #1;
        chk("t3_drop_wren2", 32'(mem_wren),  32'd0);
        chk("t3_head_valid", 32'(out_valid), 32'd1);
        chk("t3_head",       32'(out_data),  32'h5A);
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("t3_pop_oen",   32'(mem_oen),  32'd1);
        chk("t3_pop_ready", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
        #1;
        chk("t3_ready_back", 32'(in_ready), 32'd1);
        chk("t3_next_head",  32'(out_data), 32'h5B);
        out_ready = 1'b1; got = 1;
        for (int c = 0; c < 2100 && got < 2049; c++) begin
            #1;
            if (out_valid) begin
                expb = 8'(got) ^ 8'h5A;
                chk("t3_drain", 32'(out_data), 32'(expb));
                got++;
            end
            step();
        end
        #1;
        chk("t3_drained", 32'(got),       32'd2049);
        chk("t3_empty",   32'(out_valid), 32'd0);
        step();

        // 4: 3000 words through the 2048-deep BRAM, pointers wrap
        out_ready = 1'b1; sent = 0; got = 0; wrapw = 0; wrapr = 0;
        prev_waddr = '0; prev_raddr = '0;
        for (int c = 0; c < 3100 && got < 3000; c++) begin
            in_valid = (sent < 3000);
            in_data  = 8'(sent * 7 + 3);
            #1;
            if (mem_wren) begin
                if (prev_waddr == 11'd2047 && mem_waddr == 11'd0) wrapw = 1;
                prev_waddr = mem_waddr;
            end
            if (mem_oen) begin
                if (prev_raddr == 11'd2047 && mem_raddr == 11'd0) wrapr = 1;
                prev_raddr = mem_raddr;
            end
            if (in_valid && in_ready) sent++;
            if (out_valid) begin
                expb = 8'(got * 7 + 3);
                chk("t4_data", 32'(out_data), 32'(expb));
                got++;
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("t4_count", 32'(got),   32'd3000);
        chk("t4_wrapw", 32'(wrapw), 32'd1);
        chk("t4_wrapr", 32'(wrapr), 32'd1);
        step();

        // 5: head 0x3C stalled for 10 cycles while writes continue
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
        step();
        in_valid = 1'b0;
        step();
        #1;
        chk("t5_head_valid", 32'(out_valid), 32'd1);
        chk("t5_head",       32'(out_data),  32'h3C);
        step();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h80 + k);
            #1;
            chk("t5_stall_data", 32'(out_data), 32'h3C);
            chk("t5_stall_oen",  32'(mem_oen),  32'd0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; got = 0;
        for (int c = 0; c < 20 && got < 11; c++) begin
            #1;
            if (out_valid) begin
                expb = (got == 0) ? 8'h3C : 8'(8'h80 + got - 1);
                chk("t5_drain", 32'(out_data), 32'(expb));
                got++;
            end
            step();
        end
        chk("t5_count", 32'(got), 32'd11);

        // 6: reset with 100 words queued flushes the FIFO
        out_ready = 1'b0;
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(c);
            step();
        end
        in_valid = 1'b0;
        #1;
        chk("t6_queued_valid", 32'(out_valid), 32'd1);
`ifdef BRAM_FIFO_LEVEL_EN
        chk("t6_level_100", 32'(level),       32'd100);
        chk("t6_af_100",    32'(almost_full), 32'd0);
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_ov",    32'(out_valid), 32'd0);
        chk("t6_ready", 32'(in_ready),  32'd1);
        chk("t6_oen",   32'(mem_oen),   32'd0);
`ifdef BRAM_FIFO_LEVEL_EN
        chk("t6_level", 32'(level),     32'd0);
`endif
        in_valid = 1'b1; in_data = 8'hC3;
        #1;
        chk("t6_wren",  32'(mem_wren),  32'd1);
        chk("t6_waddr", 32'(mem_waddr), 32'd0);
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'd1);
        chk("t6_out_data",  32'(out_data),  32'hC3);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
